ddram_rom_loader: RTL and testbench
===================================

Name: ddram_rom_loader

Overview:
- Sequences the shared DDRAM port between ROM download (byte stream from hps_io ioctl) and the game core's 64-bit ROM read requests.
- Packs download bytes into 64-bit words with byte enables, writes them at BASE_ADDR, and back-pressures the download with dl_wait.
- After download, services single-word core reads; sits between hps_io/AthenaCore and the emu DDRAM_* ports.

Parameters:
- BASE_ADDR, 29'h0060_0000, DDRAM 64-bit word address of byte 0 of the ROM region.
- DL_AW, 25, width of download byte address.
- RD_AW, 22, width of core read word address.

Ports:
- clk_sys  in  1  system clock (53.6 MHz); DDRAM_CLK is driven from it.
- reset  in  1  synchronous, active-high.
- dl_active  in  1  download in progress (ioctl_download && index match).
- dl_wr  in  1  one-cycle byte strobe.
- dl_addr  in  DL_AW  byte address.
- dl_data  in  8  byte data.
- dl_wait  out  1  stall to hps_io (ioctl_wait).
- dl_done  out  1  all download data committed to DDRAM.
- rd_req  in  1  level request, held until rd_ack.
- rd_addr  in  RD_AW  word offset from BASE_ADDR.
- rd_data  out  64  read data, valid with rd_ack and held until the next ack.
- rd_ack  out  1  one-cycle pulse.
- DDRAM_CLK  out  1.
- DDRAM_BUSY  in  1.
- DDRAM_BURSTCNT  out  8  constant 1.
- DDRAM_ADDR  out  29.
- DDRAM_DOUT  in  64.
- DDRAM_DOUT_READY  in  1.
- DDRAM_RD  out  1.
- DDRAM_DIN  out  64.
- DDRAM_BE  out  8.
- DDRAM_WE  out  1.

Behaviour:
- Reset values: dl_wait=0, dl_done=0, rd_ack=0, rd_data=0, DDRAM_RD=0, DDRAM_WE=0, DDRAM_BE=0, DDRAM_ADDR=0, DDRAM_DIN=0. Pack buffer, pending byte and FSM are cleared.
- Reset mid-operation aborts any outstanding command with no completion.
- Pack buffer: wbuf[63:0], be_acc[7:0], cur_word = dl_addr[DL_AW-1:3].
- Lane L = dl_addr[2:0]. An accepted byte writes wbuf[8L+7:8L] and sets be_acc[L] (little-endian).
- Accept rules for dl_wr in state IDLE:
  - be_acc==0 or same word: merge the byte; set cur_word.
  - Different word with be_acc!=0: store the byte in the pending register and request a flush. The pending byte is merged the cycle after the flush completes.
  - L==7 after merge: request a flush.
- End of download: falling edge of dl_active with be_acc!=0 requests a flush.
- dl_done rises the cycle after the final flush completes, or on the falling edge if be_acc==0. It clears on the dl_active rising edge.
- dl_wait is registered. It goes high the cycle after any flush request and drops the cycle after the write is accepted and the pending byte is merged.
- dl_wr arriving while dl_wait=1 is a protocol error: ignore it, no state change. hps_io spaces strobes by at least 2 cycles.
- FSM states: IDLE, WR, RD, RD_WAIT.
- IDLE:
  - Flush pending -> WR. Drive DDRAM_WE=1, ADDR=BASE_ADDR+cur_word, DIN=wbuf, BE=be_acc.
  - Else rd_req && !dl_active -> RD. Drive DDRAM_RD=1, ADDR=BASE_ADDR+rd_addr, BE=8'hFF.
  - A flush always beats a read in the same cycle. Reads are never started while dl_active=1.
- WR: hold WE/ADDR/DIN/BE while DDRAM_BUSY=1. On the first cycle with BUSY=0 the write is accepted: next cycle WE=0, be_acc cleared, pending byte merged, -> IDLE.
- RD: hold RD/ADDR while BUSY=1. On acceptance, RD=0 -> RD_WAIT.
- RD_WAIT: on DDRAM_DOUT_READY, rd_data<=DDRAM_DOUT and rd_ack=1 for one cycle -> IDLE.
  - A flush request arriving here waits; the read completes first.
  - rd_req must be held; the next read can start no earlier than the cycle after rd_ack.
- Address arithmetic is 29-bit, modulo 2^29 with no saturation. BURSTCNT is always 8'd1.
- Minimum latencies with BUSY=0 and DOUT_READY one cycle after RD:
  - Read: rd_req to rd_ack = 4 cycles.
  - Write: byte 7 strobe to WE = 2 cycles.

Test Plan:
- Download bytes 0x00..0x0F at addresses 0..15, one strobe every 4 cycles, BUSY=0 -> two writes: ADDR=BASE_ADDR, DIN=64'h0706050403020100, BE=FF; then ADDR=BASE_ADDR+1, DIN=64'h0F0E0D0C0B0A0908; dl_done=1 after dl_active falls.
- Download 3 bytes (addr 0..2 = AA,BB,CC), then drop dl_active -> one write: BE=8'h07, DIN[23:0]=24'hCCBBAA, dl_done rises after acceptance.
- Address jump: bytes at 5 then 16 -> first write ADDR=BASE_ADDR, BE=8'h20; then pending byte merged into word 2, BE=8'h01; dl_wait high across the flush.
- BUSY held high 10 cycles during a write -> WE/ADDR/DIN/BE stable all 10 cycles, dl_wait high throughout, no extra write issued.
- rd_req with rd_addr=3 asserted in the same cycle as a flush request -> write issued first, then RD at BASE_ADDR+3; rd_data equals the DOUT presented, rd_ack exactly one cycle.
- Assert reset during RD_WAIT -> next cycle all outputs at reset values; a later DOUT_READY produces no rd_ack.

Source files
------------

// File: rtl/ddram_rom_loader.sv
// Shares the DDRAM port between the ROM download (bytes packed into 64-bit
// words with byte enables) and single-word ROM reads from the core.
`timescale 1ns/1ps
module ddram_rom_loader #(
  parameter logic [28:0] BASE_ADDR = 29'h0060_0000,
  parameter int          DL_AW     = 25,
  parameter int          RD_AW     = 22
) (
  input  logic             clk_sys,
  input  logic             reset,
  input  logic             dl_active,
  input  logic             dl_wr,
  input  logic [DL_AW-1:0] dl_addr,
  input  logic [7:0]       dl_data,
  output logic             dl_wait,
  output logic             dl_done,
  input  logic             rd_req,
  input  logic [RD_AW-1:0] rd_addr,
  output logic [63:0]      rd_data,
  output logic             rd_ack,
  output logic             DDRAM_CLK,
  input  logic             DDRAM_BUSY,
  output logic [7:0]       DDRAM_BURSTCNT,
  output logic [28:0]      DDRAM_ADDR,
  input  logic [63:0]      DDRAM_DOUT,
  input  logic             DDRAM_DOUT_READY,
  output logic             DDRAM_RD,
  output logic [63:0]      DDRAM_DIN,
  output logic [7:0]       DDRAM_BE,
  output logic             DDRAM_WE
);

  localparam int WW = DL_AW - 3;

  typedef enum logic [1:0] {IDLE, WR, RD, RD_WAIT} state_t;
  state_t state, state_nxt;

  logic [63:0]   wbuf;
  logic [7:0]    be_acc;
  logic [WW-1:0] cur_word;
  logic          pend_vld;
  logic [2:0]    pend_lane;
  logic [7:0]    pend_data;
  logic [WW-1:0] pend_word;
  logic          flush_req;
  logic          end_pend;
  logic          act_q;

  logic          rd_nxt, we_nxt, ack_nxt;
  logic [28:0]   addr_nxt;
  logic [63:0]   din_nxt;
  logic [7:0]    be_nxt;

  logic [2:0]    lane;
  logic [WW-1:0] word;
  logic          wr_acc, wr_go, fall, rise, end_now;

  assign DDRAM_CLK      = clk_sys;
  assign DDRAM_BURSTCNT = 8'd1;

  assign lane    = dl_addr[2:0];
  assign word    = dl_addr[DL_AW-1:3];
  assign wr_acc  = dl_wr && !dl_wait;
  assign wr_go   = (state == WR) && !DDRAM_BUSY;
  assign fall    = act_q && !dl_active;
  assign rise    = !act_q && dl_active;
  assign end_now = end_pend || fall;

  // Reads also wait one cycle past the dl_active fall so the end-of-download
  // flush is always registered ahead of them.
  always_comb begin
    state_nxt = state;
    rd_nxt    = 1'b0;
    we_nxt    = 1'b0;
    ack_nxt   = 1'b0;
    addr_nxt  = DDRAM_ADDR;
    din_nxt   = DDRAM_DIN;
    be_nxt    = DDRAM_BE;
    case (state)
      IDLE: begin
        if (flush_req) begin
          state_nxt = WR;
          we_nxt    = 1'b1;
          addr_nxt  = BASE_ADDR + 29'(cur_word);
          din_nxt   = wbuf;
          be_nxt    = be_acc;
        end else if (rd_req && !dl_active && !act_q && !rd_ack) begin
          state_nxt = RD;
          rd_nxt    = 1'b1;
          addr_nxt  = BASE_ADDR + 29'(rd_addr);
          be_nxt    = 8'hFF;
        end
      end
      WR: begin
        if (DDRAM_BUSY) we_nxt = 1'b1;
        else            state_nxt = IDLE;
      end
      RD: begin
        if (DDRAM_BUSY) rd_nxt = 1'b1;
        else            state_nxt = RD_WAIT;
      end
      RD_WAIT: begin
        if (DDRAM_DOUT_READY) begin
          ack_nxt   = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state      <= IDLE;
      DDRAM_RD   <= 1'b0;
      DDRAM_WE   <= 1'b0;
      DDRAM_ADDR <= '0;
      DDRAM_DIN  <= '0;
      DDRAM_BE   <= '0;
      rd_ack     <= 1'b0;
      rd_data    <= '0;
    end else begin
      state      <= state_nxt;
      DDRAM_RD   <= rd_nxt;
      DDRAM_WE   <= we_nxt;
      DDRAM_ADDR <= addr_nxt;
      DDRAM_DIN  <= din_nxt;
      DDRAM_BE   <= be_nxt;
      rd_ack     <= ack_nxt;
      if (ack_nxt) rd_data <= DDRAM_DOUT;
    end
  end

  // Download packing. Strobes are only taken while dl_wait is low, so they
  // never coincide with a write being accepted.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      wbuf      <= '0;
      be_acc    <= '0;
      cur_word  <= '0;
      pend_vld  <= 1'b0;
      pend_lane <= '0;
      pend_data <= '0;
      pend_word <= '0;
      flush_req <= 1'b0;
      end_pend  <= 1'b0;
      act_q     <= 1'b0;
      dl_wait   <= 1'b0;
      dl_done   <= 1'b0;
    end else begin
      act_q <= dl_active;
      if (rise) begin
        dl_done  <= 1'b0;
        end_pend <= 1'b0;
      end
      if (wr_acc) begin
        if (be_acc == 8'd0 || word == cur_word) begin
          wbuf[{lane, 3'b000} +: 8] <= dl_data;
          be_acc[lane]              <= 1'b1;
          cur_word                  <= word;
          if (lane == 3'd7) begin
            flush_req <= 1'b1;
            dl_wait   <= 1'b1;
          end
        end else begin
          pend_vld  <= 1'b1;
          pend_lane <= lane;
          pend_data <= dl_data;
          pend_word <= word;
          flush_req <= 1'b1;
          dl_wait   <= 1'b1;
        end
      end
      if (fall) begin
        if (flush_req) begin
          end_pend <= 1'b1;
        end else if (be_acc != 8'd0) begin
          flush_req <= 1'b1;
          dl_wait   <= 1'b1;
          end_pend  <= 1'b1;
        end else begin
          dl_done <= 1'b1;
        end
      end
      if (wr_go) begin
        if (pend_vld) begin
          wbuf     <= 64'(pend_data) << {pend_lane, 3'b000};
          be_acc   <= 8'd1 << pend_lane;
          cur_word <= pend_word;
          pend_vld <= 1'b0;
          // A merged byte that completes its word, or arrives after the
          // download ended, must go straight back out.
          if (pend_lane != 3'd7 && !end_now) begin
            flush_req <= 1'b0;
            dl_wait   <= 1'b0;
          end
        end else begin
          wbuf      <= '0;
          be_acc    <= '0;
          flush_req <= 1'b0;
          dl_wait   <= 1'b0;
          if (end_now) begin
            dl_done  <= 1'b1;
            end_pend <= 1'b0;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_ddram_rom_loader.sv
// Directed bench for ddram_rom_loader: a word-packing model plus a DDRAM
// responder, checked every cycle, with literal spot checks per scenario.
`timescale 1ns/1ps
module tb_ddram_rom_loader;
  localparam logic [28:0] BASE = 29'h0060_0000;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic        dl_active, dl_wr;
  logic [24:0] dl_addr;
  logic [7:0]  dl_data;
  logic        dl_wait, dl_done;
  logic        rd_req;
  logic [21:0] rd_addr;
  logic [63:0] rd_data;
  logic        rd_ack;
  logic        DDRAM_CLK, DDRAM_BUSY, DDRAM_DOUT_READY, DDRAM_RD, DDRAM_WE;
  logic [7:0]  DDRAM_BURSTCNT, DDRAM_BE;
  logic [28:0] DDRAM_ADDR;
  logic [63:0] DDRAM_DOUT, DDRAM_DIN;

  ddram_rom_loader dut (
    .clk_sys(clk_sys), .reset(reset), .dl_active(dl_active), .dl_wr(dl_wr),
    .dl_addr(dl_addr), .dl_data(dl_data), .dl_wait(dl_wait), .dl_done(dl_done),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_data(rd_data), .rd_ack(rd_ack),
    .DDRAM_CLK(DDRAM_CLK), .DDRAM_BUSY(DDRAM_BUSY), .DDRAM_BURSTCNT(DDRAM_BURSTCNT),
    .DDRAM_ADDR(DDRAM_ADDR), .DDRAM_DOUT(DDRAM_DOUT), .DDRAM_DOUT_READY(DDRAM_DOUT_READY),
    .DDRAM_RD(DDRAM_RD), .DDRAM_DIN(DDRAM_DIN), .DDRAM_BE(DDRAM_BE), .DDRAM_WE(DDRAM_WE)
  );

  always #5 clk_sys = ~clk_sys;

  int checks = 0, errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out", name);
  endtask

  // ---- model: bytes of one word gather until the word completes (lane 7),
  // the stream moves to another word, or the download ends.
  typedef struct { logic [28:0] addr; logic [63:0] din; logic [7:0] be; } wr_t;
  wr_t         exp_w[$];
  wr_t         wlog[$];
  logic [63:0] exp_r[$];
  logic [21:0] m_word;
  logic [63:0] m_buf = '0;
  logic [7:0]  m_be = '0;

  function automatic void m_emit();
    wr_t w;
    w.addr = BASE + 29'(m_word);
    w.din  = m_buf;
    w.be   = m_be;
    exp_w.push_back(w);
    m_buf = '0;
    m_be  = '0;
  endfunction

  function automatic void m_byte(input logic [24:0] a, input logic [7:0] d);
    int l;
    l = int'(a[2:0]);
    if (m_be != 0 && a[24:3] != m_word) m_emit();
    m_word = a[24:3];
    m_buf[l*8 +: 8] = d;
    m_be[l] = 1'b1;
    if (l == 7) m_emit();
  endfunction

  function automatic void m_end();
    if (m_be != 0) m_emit();
  endfunction

  function automatic logic [63:0] mem_f(input logic [28:0] a);
    return 64'hA5A5_0000_0000_0000 | 64'(a);
  endfunction

  // ---- DDRAM read responder: data two cycles after the read is accepted
  logic        auto_ready = 1'b1, force_ready = 1'b0;
  logic [63:0] force_dout = '0;
  logic        go_now, go_d = 1'b0;
  logic [28:0] a_now, a_d = '0;

  always @(posedge clk_sys) begin
    go_now = DDRAM_RD && !DDRAM_BUSY;
    a_now  = DDRAM_ADDR;
    #2;
    DDRAM_DOUT_READY = (go_d && auto_ready) || force_ready;
    DDRAM_DOUT       = go_d ? mem_f(a_d) : force_dout;
    go_d = go_now;
    a_d  = a_now;
  end

  // ---- per-cycle compare
  int          cyc = 0, wr_cyc = 0, rd_cyc = 0, ack_cnt = 0;
  logic [28:0] rd_log_addr = '0, h_addr = '0;
  logic [63:0] h_din = '0, msk;
  logic [7:0]  h_be = '0;
  logic        prev_hold = 1'b0, prev_ack = 1'b0;
  wr_t         cw, lw;

  always @(negedge clk_sys) begin
    cyc++;
    if (!reset) begin
      if (prev_hold) begin
        chk("hold_we", 64'(DDRAM_WE), 64'd1);
        chk("hold_addr", 64'(DDRAM_ADDR), 64'(h_addr));
        chk("hold_din", DDRAM_DIN, h_din);
        chk("hold_be", 64'(DDRAM_BE), 64'(h_be));
      end
      prev_hold = DDRAM_WE && DDRAM_BUSY;
      h_addr = DDRAM_ADDR; h_din = DDRAM_DIN; h_be = DDRAM_BE;
      if (DDRAM_WE) chk("wait_during_we", 64'(dl_wait), 64'd1);
      if (DDRAM_WE && !DDRAM_BUSY) begin
        lw.addr = DDRAM_ADDR; lw.din = DDRAM_DIN; lw.be = DDRAM_BE;
        wlog.push_back(lw);
        wr_cyc = cyc;
        if (exp_w.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_write: addr %h be %h", DDRAM_ADDR, DDRAM_BE);
        end else begin
          cw = exp_w.pop_front();
          for (int i = 0; i < 8; i++) msk[i*8 +: 8] = {8{cw.be[i]}};
          chk("wr_addr", 64'(DDRAM_ADDR), 64'(cw.addr));
          chk("wr_be", 64'(DDRAM_BE), 64'(cw.be));
          chk("wr_din", DDRAM_DIN & msk, cw.din & msk);
        end
      end
      if (DDRAM_RD && !DDRAM_BUSY) begin
        rd_cyc = cyc;
        rd_log_addr = DDRAM_ADDR;
        chk("rd_not_during_dl", 64'(dl_active), 64'd0);
      end
      if (rd_ack) begin
        ack_cnt++;
        if (prev_ack) begin
          checks++; errors++;
          $display("FAIL ack_pulse: rd_ack high two cycles, expected one");
        end
        if (exp_r.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_ack: rd_data %h, no read outstanding", rd_data);
        end else begin
          chk("rd_data", rd_data, exp_r.pop_front());
        end
      end
      prev_ack = rd_ack;
    end else begin
      prev_hold = 1'b0;
      prev_ack  = 1'b0;
    end
  end

  // ---- stimulus
  logic wait_after;
  int   base, n, acks0;

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic strobe(input logic [24:0] a, input logic [7:0] d);
    dl_addr = a; dl_data = d; dl_wr = 1'b1;
    m_byte(a, d);
    tick();
    dl_wr = 1'b0;
    wait_after = dl_wait;
  endtask

  task automatic send_byte(input logic [24:0] a, input logic [7:0] d);
    int k = 0;
    while (dl_wait && k < 100) begin tick(); k++; end
    if (k >= 100) fail_now("dl_wait_release");
    strobe(a, d);
    repeat (3) tick();
  endtask

  task automatic wait_done();
    int k = 0;
    while (!dl_done && k < 100) begin tick(); k++; end
    if (k >= 100) fail_now("dl_done_rise");
  endtask

  task automatic reset_vals(input string tag);
    chk({tag, "_dl_wait"}, 64'(dl_wait), 64'd0);
    chk({tag, "_dl_done"}, 64'(dl_done), 64'd0);
    chk({tag, "_rd_ack"}, 64'(rd_ack), 64'd0);
    chk({tag, "_rd_data"}, rd_data, 64'd0);
    chk({tag, "_ddram_rd"}, 64'(DDRAM_RD), 64'd0);
    chk({tag, "_ddram_we"}, 64'(DDRAM_WE), 64'd0);
    chk({tag, "_ddram_be"}, 64'(DDRAM_BE), 64'd0);
    chk({tag, "_ddram_addr"}, 64'(DDRAM_ADDR), 64'd0);
    chk({tag, "_ddram_din"}, DDRAM_DIN, 64'd0);
  endtask

  initial begin
    reset = 1'b1; dl_active = 1'b0; dl_wr = 1'b0; dl_addr = '0; dl_data = '0;
    rd_req = 1'b0; rd_addr = '0; DDRAM_BUSY = 1'b0;
    DDRAM_DOUT_READY = 1'b0; DDRAM_DOUT = '0;
    repeat (3) tick();
    reset_vals("reset");
    chk("burstcnt", 64'(DDRAM_BURSTCNT), 64'd1);
    reset = 1'b0;
    tick();

    // 16 sequential bytes -> two full words
    base = wlog.size();
    dl_active = 1'b1; tick(); tick();
    for (int i = 0; i < 16; i++) send_byte(25'(i), 8'(i));
    dl_active = 1'b0; m_end();
    wait_done();
    chk("t1_nwrites", 64'(wlog.size() - base), 64'd2);
    chk("t1_addr0", 64'(wlog[base].addr), 64'h0060_0000);
    chk("t1_din0", wlog[base].din, 64'h0706050403020100);
    chk("t1_be0", 64'(wlog[base].be), 64'hFF);
    chk("t1_addr1", 64'(wlog[base+1].addr), 64'h0060_0001);
    chk("t1_din1", wlog[base+1].din, 64'h0F0E0D0C0B0A0908);

    // 3-byte tail flushed by the dl_active fall
    dl_active = 1'b1; tick(); tick();
    chk("done_clear_on_rise", 64'(dl_done), 64'd0);
    base = wlog.size();
    send_byte(25'd0, 8'hAA); send_byte(25'd1, 8'hBB); send_byte(25'd2, 8'hCC);
    dl_active = 1'b0; m_end();
    tick();
    chk("done_before_flush", 64'(dl_done), 64'd0);
    wait_done();
    chk("t2_nwrites", 64'(wlog.size() - base), 64'd1);
    chk("t2_addr", 64'(wlog[base].addr), 64'h0060_0000);
    chk("t2_be", 64'(wlog[base].be), 64'h07);
    chk("t2_din", 64'(wlog[base].din[23:0]), 64'hCCBBAA);

    // address jump: byte 5 then byte 16
    dl_active = 1'b1; tick(); tick();
    base = wlog.size();
    send_byte(25'd5, 8'h55);
    chk("no_wait_mid_word", 64'(wait_after), 64'd0);
    send_byte(25'd16, 8'h66);
    chk("wait_on_jump", 64'(wait_after), 64'd1);
    dl_active = 1'b0; m_end();
    wait_done();
    chk("t3_nwrites", 64'(wlog.size() - base), 64'd2);
    chk("t3_addr0", 64'(wlog[base].addr), 64'h0060_0000);
    chk("t3_be0", 64'(wlog[base].be), 64'h20);
    chk("t3_din0", 64'(wlog[base].din[47:40]), 64'h55);
    chk("t3_addr1", 64'(wlog[base+1].addr), 64'h0060_0002);
    chk("t3_be1", 64'(wlog[base+1].be), 64'h01);
    chk("t3_din1", 64'(wlog[base+1].din[7:0]), 64'h66);

    // BUSY held for 10 cycles across a write
    dl_active = 1'b1; tick(); tick();
    base = wlog.size();
    DDRAM_BUSY = 1'b1;
    strobe(25'h1F, 8'h77);
    n = 0;
    while (!DDRAM_WE && n < 20) begin tick(); n++; end
    if (n >= 20) fail_now("we_rise");
    for (int i = 0; i < 10; i++) begin
      chk("busy_we", 64'(DDRAM_WE), 64'd1);
      chk("busy_wait", 64'(dl_wait), 64'd1);
      chk("busy_addr", 64'(DDRAM_ADDR), 64'h0060_0003);
      chk("busy_be", 64'(DDRAM_BE), 64'h80);
      chk("busy_din", 64'(DDRAM_DIN[63:56]), 64'h77);
      tick();
    end
    DDRAM_BUSY = 1'b0;
    tick(); tick();
    dl_active = 1'b0; m_end();
    wait_done();
    chk("single_write_under_busy", 64'(wlog.size() - base), 64'd1);

    // read requested together with the end-of-download flush
    dl_active = 1'b1; tick(); tick();
    send_byte(25'd8, 8'h99);
    dl_active = 1'b0; m_end();
    rd_addr = 22'd3; rd_req = 1'b1;
    exp_r.push_back(mem_f(BASE + 29'd3));
    n = 0;
    while (!rd_ack && n < 50) begin tick(); n++; end
    if (n >= 50) fail_now("rd_ack_flush_race");
    rd_req = 1'b0;
    chk("t5_rd_data", rd_data, 64'hA5A5_0000_0060_0003);
    chk("t5_rd_addr", 64'(rd_log_addr), 64'h0060_0003);
    chk("t5_write_first", 64'(wr_cyc < rd_cyc), 64'd1);
    tick();
    chk("t5_ack_one_cycle", 64'(rd_ack), 64'd0);
    wait_done();

    // idle read at the top word offset; req cycle through ack cycle spans 5
    rd_addr = 22'h3F_FFFF; rd_req = 1'b1;
    exp_r.push_back(mem_f(BASE + 29'h3F_FFFF));
    n = 0;
    while (!rd_ack && n < 50) begin tick(); n++; end
    rd_req = 1'b0;
    chk("rd_latency", 64'(n), 64'd4);
    chk("rd_addr_top", 64'(rd_log_addr), 64'h009F_FFFF);
    tick();

    // reset while waiting for read data
    auto_ready = 1'b0;
    rd_addr = 22'd5; rd_req = 1'b1;
    n = 0;
    while (!DDRAM_RD && n < 20) begin tick(); n++; end
    if (n >= 20) fail_now("rd_issue");
    tick();
    chk("in_rd_wait", 64'(DDRAM_RD), 64'd0);
    acks0 = ack_cnt;
    reset = 1'b1; rd_req = 1'b0;
    tick();
    reset_vals("midreset");
    reset = 1'b0;
    tick();
    force_dout = 64'h1234_5678_9ABC_DEF0; force_ready = 1'b1;
    tick();
    force_ready = 1'b0;
    repeat (4) tick();
    chk("no_ack_after_reset", 64'(ack_cnt - acks0), 64'd0);
    chk("rd_data_still_reset", rd_data, 64'd0);
    chk("writes_all_seen", 64'(exp_w.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
